// File: rtl/trdb_itype_detector_mr.sv
// Multi-retirement itype classifier: holds one beat and emits it with per-lane itypes
// once its successor is known. Optional feature macro: TRDB_IMPLICIT_RET_EN.
module trdb_itype_detector_mr #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NRET = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [NRET-1:0]      in_mask_i,
    input  logic [NRET*XLEN-1:0] in_iaddr_i,
    input  logic [NRET*32-1:0]   in_inst_i,
    input  logic [NRET-1:0]      in_compressed_i,
    input  logic [NRET-1:0]      in_exception_i,
    input  logic [NRET-1:0]      in_interrupt_i,
    input  logic                 flush_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [NRET-1:0]      out_mask_o,
    output logic [NRET*XLEN-1:0] out_iaddr_o,
    output logic [NRET*3-1:0]    out_itype_o,
    output logic [NRET-1:0]      out_updiscon_o,
    output logic                 out_unresolved_o
);

    localparam int unsigned ILEN = 32;
    localparam int unsigned TW   = 3;

    localparam logic [ILEN-1:0] MASK_BRANCH   = 32'h0000_707f;
    localparam logic [ILEN-1:0] MATCH_BEQ     = 32'h0000_0063;
    localparam logic [ILEN-1:0] MATCH_BNE     = 32'h0000_1063;
    localparam logic [ILEN-1:0] MATCH_BLT     = 32'h0000_4063;
    localparam logic [ILEN-1:0] MATCH_BGE     = 32'h0000_5063;
    localparam logic [ILEN-1:0] MATCH_BLTU    = 32'h0000_6063;
    localparam logic [ILEN-1:0] MATCH_BGEU    = 32'h0000_7063;
    localparam logic [ILEN-1:0] MATCH_P_BEQIMM = 32'h0000_2063;
    localparam logic [ILEN-1:0] MATCH_P_BNEIMM = 32'h0000_3063;
    localparam logic [ILEN-1:0] MASK_C_BRANCH = 32'h0000_e003;
    localparam logic [ILEN-1:0] MATCH_C_BEQZ  = 32'h0000_c001;
    localparam logic [ILEN-1:0] MATCH_C_BNEZ  = 32'h0000_e001;
    localparam logic [ILEN-1:0] MASK_JALR     = 32'h0000_707f;
    localparam logic [ILEN-1:0] MATCH_JALR    = 32'h0000_0067;
    localparam logic [ILEN-1:0] MASK_XRET     = 32'hffff_ffff;
    localparam logic [ILEN-1:0] MATCH_MRET    = 32'h3020_0073;
    localparam logic [ILEN-1:0] MATCH_SRET    = 32'h1020_0073;

    localparam logic [TW-1:0] ITYPE_NONE  = 3'd0;
    localparam logic [TW-1:0] ITYPE_EXC   = 3'd1;
    localparam logic [TW-1:0] ITYPE_INTR  = 3'd2;
    localparam logic [TW-1:0] ITYPE_XRET  = 3'd3;
    localparam logic [TW-1:0] ITYPE_BR_NT = 3'd4;
    localparam logic [TW-1:0] ITYPE_BR_T  = 3'd5;
    localparam logic [TW-1:0] ITYPE_JALR  = 3'd6;
`ifdef TRDB_IMPLICIT_RET_EN
    localparam logic [TW-1:0] ITYPE_RET   = 3'd7;
`endif

    function automatic logic is_branch(input logic [ILEN-1:0] inst, input logic comp);
        logic hit;
        if (comp) begin
            hit = ((inst & MASK_C_BRANCH) == MATCH_C_BEQZ) ||
                  ((inst & MASK_C_BRANCH) == MATCH_C_BNEZ);
        end else begin
            hit = ((inst & MASK_BRANCH) == MATCH_BEQ)      ||
                  ((inst & MASK_BRANCH) == MATCH_BNE)      ||
                  ((inst & MASK_BRANCH) == MATCH_BLT)      ||
                  ((inst & MASK_BRANCH) == MATCH_BGE)      ||
                  ((inst & MASK_BRANCH) == MATCH_BLTU)     ||
                  ((inst & MASK_BRANCH) == MATCH_BGEU)     ||
                  ((inst & MASK_BRANCH) == MATCH_P_BEQIMM) ||
                  ((inst & MASK_BRANCH) == MATCH_P_BNEIMM);
        end
        return hit;
    endfunction

    function automatic logic is_xret(input logic [ILEN-1:0] inst, input logic comp);
        return !comp && (((inst & MASK_XRET) == MATCH_MRET) ||
                         ((inst & MASK_XRET) == MATCH_SRET));
    endfunction

    function automatic logic is_jalr(input logic [ILEN-1:0] inst, input logic comp);
        return !comp && ((inst & MASK_JALR) == MATCH_JALR);
    endfunction

`ifdef TRDB_IMPLICIT_RET_EN
    // jalr x0, off(ra|t0): conventional function return
    function automatic logic is_ret(input logic [ILEN-1:0] inst);
        return (inst[11:7] == 5'd0) && ((inst[19:15] == 5'd1) || (inst[19:15] == 5'd5));
    endfunction
`endif

    logic                 pend_q;
    logic [NRET-1:0]      mask_q;
    logic [NRET*XLEN-1:0] iaddr_q;
    logic [NRET*ILEN-1:0] inst_q;
    logic [NRET-1:0]      comp_q;
    logic [NRET-1:0]      exc_q;
    logic [NRET-1:0]      intr_q;

    logic have_succ;
    logic accept;
    logic out_fire;

    assign have_succ        = in_valid_i && (|in_mask_i);
    assign in_ready_o       = !pend_q || out_ready_i;
    assign out_valid_o      = pend_q && (have_succ || flush_i);
    assign out_unresolved_o = pend_q && flush_i && !have_succ;
    assign accept           = have_succ && in_ready_o;
    assign out_fire         = out_valid_o && out_ready_i;
    assign out_mask_o       = mask_q;
    assign out_iaddr_o      = iaddr_q;

    // Pending beat; zero-mask beats never load
    always_ff @(posedge clk_i or negedge rst_ni) begin : pend_reg
        if (!rst_ni) begin
            pend_q  <= 1'b0;
            mask_q  <= '0;
            iaddr_q <= '0;
            inst_q  <= '0;
            comp_q  <= '0;
            exc_q   <= '0;
            intr_q  <= '0;
        end else if (accept) begin
            pend_q  <= 1'b1;
            mask_q  <= in_mask_i;
            iaddr_q <= in_iaddr_i;
            inst_q  <= in_inst_i;
            comp_q  <= in_compressed_i;
            exc_q   <= in_exception_i;
            intr_q  <= in_interrupt_i;
        end else if (out_fire) begin
            pend_q  <= 1'b0;
            mask_q  <= '0;
        end
    end

    for (genvar g = 0; g < NRET; g++) begin : g_lane
        logic [ILEN-1:0] inst;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] succ;
        logic [XLEN-1:0] seq;
        logic            is_last;
        logic            known;
        logic            taken;
        logic [TW-1:0]   itype;

        assign inst = inst_q[g*ILEN +: ILEN];
        assign addr = iaddr_q[g*XLEN +: XLEN];

        // Successor is the next pending lane, or incoming lane 0 for the last valid lane
        if (g == NRET - 1) begin : g_tail
            assign is_last = mask_q[g];
            assign succ    = in_iaddr_i[XLEN-1:0];
        end else begin : g_body
            assign is_last = mask_q[g] && !mask_q[g+1];
            assign succ    = is_last ? in_iaddr_i[XLEN-1:0] : iaddr_q[(g+1)*XLEN +: XLEN];
        end

        assign seq   = addr + (comp_q[g] ? XLEN'(2) : XLEN'(4));
        assign known = !is_last || have_succ;
        assign taken = known && (succ != seq);

        always_comb begin : classify
            itype = ITYPE_NONE;
            if (!mask_q[g]) begin
                itype = ITYPE_NONE;
            end else if (intr_q[g]) begin
                itype = ITYPE_INTR;
            end else if (exc_q[g]) begin
                itype = ITYPE_EXC;
            end else if (is_xret(inst, comp_q[g])) begin
                itype = ITYPE_XRET;
            end else if (is_jalr(inst, comp_q[g])) begin
`ifdef TRDB_IMPLICIT_RET_EN
                itype = is_ret(inst) ? ITYPE_RET : ITYPE_JALR;
`else
                itype = ITYPE_JALR;
`endif
            end else if (is_branch(inst, comp_q[g])) begin
                itype = taken ? ITYPE_BR_T : ITYPE_BR_NT;
            end
        end

        assign out_itype_o[g*TW +: TW] = itype;
        assign out_updiscon_o[g]       = itype inside {3'd1, 3'd2, 3'd3, 3'd6, 3'd7};
    end

endmodule

// File: tb/tb_trdb_itype_detector_mr.sv
// Bench for trdb_itype_detector_mr: directed scenarios then random beats
// checked against a lane-level behavioural model.
module tb_trdb_itype_detector_mr;

    localparam int unsigned XLEN = 32;
    localparam int unsigned NRET = 2;

    localparam logic [31:0] I_ADDI    = 32'h0000_0013;
    localparam logic [31:0] I_BEQ     = 32'h0020_8063;
    localparam logic [31:0] I_BNE     = 32'h0020_9063;
    localparam logic [31:0] I_CBNEZ   = 32'h0000_e401;
    localparam logic [31:0] I_JALR_RA = 32'h0000_8067;
    localparam logic [31:0] I_MRET    = 32'h3020_0073;
`ifdef TRDB_IMPLICIT_RET_EN
    localparam bit RET_EN = 1'b1;
`else
    localparam bit RET_EN = 1'b0;
`endif

    logic                 clk_i = 1'b0;
    logic                 rst_ni;
    logic                 in_valid_i;
    logic                 in_ready_o;
    logic [NRET-1:0]      in_mask_i;
    logic [NRET*XLEN-1:0] in_iaddr_i;
    logic [NRET*32-1:0]   in_inst_i;
    logic [NRET-1:0]      in_compressed_i;
    logic [NRET-1:0]      in_exception_i;
    logic [NRET-1:0]      in_interrupt_i;
    logic                 flush_i;
    logic                 out_valid_o;
    logic                 out_ready_i;
    logic [NRET-1:0]      out_mask_o;
    logic [NRET*XLEN-1:0] out_iaddr_o;
    logic [NRET*3-1:0]    out_itype_o;
    logic [NRET-1:0]      out_updiscon_o;
    logic                 out_unresolved_o;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: the beat waiting for its successor
    logic            m_pend;
    logic [NRET-1:0] m_mask;
    logic [31:0]     m_addr [NRET];
    logic [31:0]     m_inst [NRET];
    logic            m_comp [NRET];
    logic            m_exc  [NRET];
    logic            m_intr [NRET];
    logic [31:0]     next_pc;

    trdb_itype_detector_mr #(.XLEN(XLEN), .NRET(NRET)) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .in_valid_i       (in_valid_i),
        .in_ready_o       (in_ready_o),
        .in_mask_i        (in_mask_i),
        .in_iaddr_i       (in_iaddr_i),
        .in_inst_i        (in_inst_i),
        .in_compressed_i  (in_compressed_i),
        .in_exception_i   (in_exception_i),
        .in_interrupt_i   (in_interrupt_i),
        .flush_i          (flush_i),
        .out_valid_o      (out_valid_o),
        .out_ready_i      (out_ready_i),
        .out_mask_o       (out_mask_o),
        .out_iaddr_o      (out_iaddr_o),
        .out_itype_o      (out_itype_o),
        .out_updiscon_o   (out_updiscon_o),
        .out_unresolved_o (out_unresolved_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // itype straight from the classification rules
    function automatic logic [2:0] exp_type(input logic [31:0] ins, input logic c, input logic e,
                                            input logic r, input logic known,
                                            input logic [31:0] a, input logic [31:0] s);
        logic br, xr, jr, rt;
        logic [31:0] fall;
        br = 1'b0; xr = 1'b0; jr = 1'b0; rt = 1'b0;
        if (c) begin
            br = (ins[1:0] == 2'b01) && (ins[15:14] == 2'b11);
        end else begin
            br = (ins[6:0] == 7'b1100011);
            jr = (ins[6:0] == 7'b1100111) && (ins[14:12] == 3'd0);
            xr = (ins == 32'h3020_0073) || (ins == 32'h1020_0073);
            rt = jr && (ins[11:7] == 5'd0) && ((ins[19:15] == 5'd1) || (ins[19:15] == 5'd5));
        end
        fall = a + (c ? 32'd2 : 32'd4);
        if (r)  return 3'd2;
        if (e)  return 3'd1;
        if (xr) return 3'd3;
        if (jr) return (rt && RET_EN) ? 3'd7 : 3'd6;
        if (br) return (known && (s != fall)) ? 3'd5 : 3'd4;
        return 3'd0;
    endfunction

    task automatic model_check();
        logic have, vld, known;
        logic [31:0] s;
        logic [2:0] t;
        int n;
        logic [NRET*3-1:0]    et;
        logic [NRET-1:0]      eu;
        logic [NRET*XLEN-1:0] ea;
        have = in_valid_i && (in_mask_i != '0);
        vld  = m_pend && (have || flush_i);
        chk("in_ready", 64'(in_ready_o), 64'(!m_pend || out_ready_i));
        chk("out_valid", 64'(out_valid_o), 64'(vld));
        chk("unresolved", 64'(out_unresolved_o), 64'(vld && !have));
        if (vld) begin
            n  = $countones(m_mask);
            et = '0;
            eu = '0;
            for (int i = 0; i < NRET; i++) begin
                ea[i*XLEN +: XLEN] = m_addr[i];
                if (i < n) begin
                    known = (i < n - 1) || have;
                    s     = (i < n - 1) ? m_addr[i+1] : in_iaddr_i[31:0];
                    t     = exp_type(m_inst[i], m_comp[i], m_exc[i], m_intr[i], known, m_addr[i], s);
                    et[i*3 +: 3] = t;
                    eu[i] = t inside {3'd1, 3'd2, 3'd3, 3'd6, 3'd7};
                end
            end
            chk("out_mask", 64'(out_mask_o), 64'(m_mask));
            chk("out_iaddr", 64'(out_iaddr_o), 64'(ea));
            chk("out_itype", 64'(out_itype_o), 64'(et));
            chk("out_updiscon", 64'(out_updiscon_o), 64'(eu));
        end
    endtask

    task automatic model_update();
        logic have, vld, rdy;
        have = in_valid_i && (in_mask_i != '0);
        vld  = m_pend && (have || flush_i);
        rdy  = !m_pend || out_ready_i;
        if (have && rdy) begin
            m_pend = 1'b1;
            m_mask = in_mask_i;
            for (int i = 0; i < NRET; i++) begin
                m_addr[i] = in_iaddr_i[i*XLEN +: XLEN];
                m_inst[i] = in_inst_i[i*32 +: 32];
                m_comp[i] = in_compressed_i[i];
                m_exc[i]  = in_exception_i[i];
                m_intr[i] = in_interrupt_i[i];
            end
        end else if (vld && out_ready_i) begin
            m_pend = 1'b0;
            m_mask = '0;
        end
    endtask

    task automatic tick();
        #1;
        model_check();
        model_update();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic idle();
        in_valid_i      = 1'b0;
        in_mask_i       = '0;
        in_iaddr_i      = '0;
        in_inst_i       = '0;
        in_compressed_i = '0;
        in_exception_i  = '0;
        in_interrupt_i  = '0;
        flush_i         = 1'b0;
        out_ready_i     = 1'b1;
    endtask

    task automatic lane(input int l, input logic [31:0] a, input logic [31:0] ins, input logic c);
        in_valid_i               = 1'b1;
        in_mask_i[l]             = 1'b1;
        in_iaddr_i[l*XLEN +: XLEN] = a;
        in_inst_i[l*32 +: 32]    = ins;
        in_compressed_i[l]       = c;
    endtask

    task automatic gen_inst(output logic [31:0] ins, output logic c);
        logic [31:0] r;
        logic [4:0]  rs, rd;
        r = $urandom;
        c = 1'b0;
        case ($urandom_range(0, 10))
            0, 1, 2: ins = {r[31:15], r[14:12], r[11:7], 7'b1100011};
            3: begin c = 1'b1; ins = {r[31:16], 2'b11, r[13:2], 2'b01}; end
            4, 5: begin
                rs  = 5'($urandom_range(0, 3));
                rs  = (rs == 5'd3) ? 5'd5 : rs;
                rd  = 5'($urandom_range(0, 1));
                ins = {r[31:20], rs, 3'b000, rd, 7'b1100111};
            end
            6: ins = r[0] ? 32'h3020_0073 : 32'h1020_0073;
            7: begin c = 1'b1; ins = r; end
            8: ins = r;
            9: ins = {r[31:15], 3'b001, r[11:7], 7'b1100111};
            default: ins = {r[31:7], 7'b0010011};
        endcase
    endtask

    task automatic gen_beat();
        int cnt;
        logic [31:0] ins;
        logic c;
        idle();
        in_valid_i = ($urandom_range(0, 9) < 7);
        if (!in_valid_i) return;
        cnt = $urandom_range(0, NRET);
        for (int l = 0; l < cnt; l++) begin
            case ($urandom_range(0, 11))
                0:       next_pc = $urandom & 32'hffff_fffe;
                1:       next_pc = 32'hffff_fffc;
                default: ;
            endcase
            gen_inst(ins, c);
            lane(l, next_pc, ins, c);
            in_exception_i[l] = ($urandom_range(0, 11) == 0);
            in_interrupt_i[l] = ($urandom_range(0, 11) == 0);
            next_pc = next_pc + (c ? 32'd2 : 32'd4);
            if ($urandom_range(0, 5) == 0) next_pc = next_pc + 32'd2;
        end
    endtask

    initial begin
        logic hold_in, hold_flush, rdy, fire, have;
        rst_ni = 1'b0;
        idle();
        m_pend = 1'b0;
        m_mask = '0;
        for (int i = 0; i < NRET; i++) begin
            m_addr[i] = '0; m_inst[i] = '0; m_comp[i] = 1'b0; m_exc[i] = 1'b0; m_intr[i] = 1'b0;
        end
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        #1;
        chk("rst_valid", 64'(out_valid_o), 64'd0);
        chk("rst_ready", 64'(in_ready_o), 64'd1);
        chk("rst_mask", 64'(out_mask_o), 64'd0);
        chk("rst_iaddr", 64'(out_iaddr_o), 64'd0);
        chk("rst_itype", 64'(out_itype_o), 64'd0);
        chk("rst_unres", 64'(out_unresolved_o), 64'd0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        idle(); lane(0, 32'h100, I_BEQ, 1'b0); lane(1, 32'h104, I_ADDI, 1'b0);
        #1 chk("first_no_out", 64'(out_valid_o), 64'd0);
        tick();
        idle(); lane(0, 32'h108, I_ADDI, 1'b0);
        #1;
        chk("beq_valid", 64'(out_valid_o), 64'd1);
        chk("beq_nt", 64'(out_itype_o[2:0]), 64'd4);
        chk("addi_lane1", 64'(out_itype_o[5:3]), 64'd0);
        chk("beq_unres", 64'(out_unresolved_o), 64'd0);
        tick();

        idle(); lane(0, 32'h200, I_CBNEZ, 1'b1); tick();
        idle(); lane(0, 32'h300, I_ADDI, 1'b0);
        #1 chk("cbnez_taken", 64'(out_itype_o[2:0]), 64'd5);
        tick();
        idle(); lane(0, 32'h200, I_CBNEZ, 1'b1); tick();
        idle(); lane(0, 32'h202, I_ADDI, 1'b0);
        #1 chk("cbnez_nt", 64'(out_itype_o[2:0]), 64'd4);
        tick();

        idle(); lane(0, 32'h400, I_JALR_RA, 1'b0); tick();
        idle(); lane(0, 32'h500, I_BEQ, 1'b0);
        #1;
        chk("jalr_ret", 64'(out_itype_o[2:0]), RET_EN ? 64'd7 : 64'd6);
        chk("jalr_updiscon", 64'(out_updiscon_o[0]), 64'd1);
        tick();

        idle(); flush_i = 1'b1;
        #1;
        chk("flush_valid", 64'(out_valid_o), 64'd1);
        chk("flush_itype", 64'(out_itype_o[2:0]), 64'd4);
        chk("flush_unres", 64'(out_unresolved_o), 64'd1);
        tick();
        #1 chk("flush_drained", 64'(out_valid_o), 64'd0);
        idle();

        idle(); lane(0, 32'h600, I_BEQ, 1'b0);
        in_exception_i[0] = 1'b1; in_interrupt_i[0] = 1'b1;
        tick();
        idle(); lane(0, 32'h604, I_ADDI, 1'b0);
        #1 chk("intr_prio", 64'(out_itype_o[2:0]), 64'd2);
        tick();
        idle(); lane(0, 32'h700, I_MRET, 1'b0); tick();
        idle(); lane(0, 32'h800, I_ADDI, 1'b0);
        #1 chk("mret", 64'(out_itype_o[2:0]), 64'd3);
        tick();

        idle(); lane(0, 32'h900, I_ADDI, 1'b0); out_ready_i = 1'b0;
        repeat (3) begin
            #1;
            chk("bp_valid", 64'(out_valid_o), 64'd1);
            chk("bp_ready", 64'(in_ready_o), 64'd0);
            chk("bp_addr", 64'(out_iaddr_o[31:0]), 64'h800);
            tick();
        end
        out_ready_i = 1'b1;
        tick();
        idle(); in_valid_i = 1'b1;
        #1;
        chk("zm_valid", 64'(out_valid_o), 64'd0);
        chk("zm_ready", 64'(in_ready_o), 64'd1);
        tick();
        idle(); lane(0, 32'h904, I_ADDI, 1'b0);
        #1;
        chk("zm_kept_valid", 64'(out_valid_o), 64'd1);
        chk("zm_kept_addr", 64'(out_iaddr_o[31:0]), 64'h900);
        tick();

        idle(); lane(0, 32'hffff_fffc, I_BEQ, 1'b0); lane(1, 32'h0, I_ADDI, 1'b0); tick();
        idle(); lane(0, 32'h4, I_ADDI, 1'b0);
        #1 chk("wrap_nt", 64'(out_itype_o[2:0]), 64'd4);
        tick();
        idle(); lane(0, 32'h1000, I_BNE, 1'b0); lane(1, 32'h2000, I_ADDI, 1'b0); tick();
        idle(); lane(0, 32'h2004, I_ADDI, 1'b0);
        #1 chk("lane_taken", 64'(out_itype_o[2:0]), 64'd5);
        tick();

        next_pc    = 32'h2008;
        hold_in    = 1'b0;
        hold_flush = 1'b0;
        for (int it = 0; it < 3000; it++) begin
            if (it == 1500) begin
                idle();
                rst_ni = 1'b0;
                #1;
                chk("midrst_valid", 64'(out_valid_o), 64'd0);
                chk("midrst_ready", 64'(in_ready_o), 64'd1);
                chk("midrst_mask", 64'(out_mask_o), 64'd0);
                m_pend = 1'b0;
                m_mask = '0;
                hold_in = 1'b0;
                hold_flush = 1'b0;
                @(posedge clk_i);
                @(negedge clk_i);
                rst_ni = 1'b1;
            end
            if (!hold_in) gen_beat();
            flush_i     = hold_flush || (m_pend && ($urandom_range(0, 9) == 0));
            out_ready_i = ($urandom_range(0, 3) != 0);
            have = in_valid_i && (in_mask_i != '0);
            rdy  = !m_pend || out_ready_i;
            fire = m_pend && (have || flush_i) && out_ready_i;
            hold_in    = in_valid_i && !rdy;
            hold_flush = flush_i && !fire;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
